protocol_ctrl: RTL and testbench



---
 rtl/protocol_pkg.sv | 25 ++
 rtl/protocol_timer.sv | 19 +
 rtl/protocol_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_protocol_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/protocol_pkg.sv
// protocol_pkg: PID and handshake encodings, controller states and width helpers
package protocol_pkg;
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010
    } pid_t;
    typedef enum logic [2:0] {
        TX_NONE  = 3'b000,
        TX_ACK   = 3'b001,
        TX_NAK   = 3'b010,
        TX_STALL = 3'b011,
        TX_DATA0 = 3'b100,
        TX_DATA1 = 3'b101
    } tx_pkt_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RX_DATA, ST_SEND, ST_TX_HS} state_t;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/protocol_timer.sv
// protocol_timer: wait bound; the cycle after restart counts as 0 and expired_o
// is high once TIMEOUT_CYCLES further cycles have passed
module protocol_timer #(
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!n_rst) cnt_q <= '0;
        else if (restart_i) cnt_q <= CNT_W'(1);
        else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
    end
    assign expired_o = !restart_i && cnt_q == CNT_W'(TIMEOUT_CYCLES);
endmodule

// File: rtl/protocol_ctrl.sv
// protocol_ctrl: multi-endpoint USB transaction FSM with per-endpoint data toggles,
// stall, host handshake wait after IN data and bounded waits
module protocol_ctrl
    import protocol_pkg::*;
#(
    parameter int NUM_EP         = 4,
    parameter int BUF_DEPTH      = 64,
    parameter int TIMEOUT_CYCLES = 128,
    localparam int EP_W          = idx_width(NUM_EP),
    localparam int OCC_W         = cnt_width(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_packet_valid,
    input  logic [3:0]        rx_packet,
    input  logic [EP_W-1:0]   rx_endpoint,
    input  logic              buffer_reserved,
    input  logic [OCC_W-1:0]  buffer_occupancy,
    input  logic [OCC_W-1:0]  tx_packet_data_size,
    input  logic              tx_busy,
    input  logic [NUM_EP-1:0] ep_stall,
    output logic              d_mode,
    output logic [2:0]        tx_packet,
    output logic [EP_W-1:0]   active_ep,
    output logic              clear,
    output logic              rx_transfer_active,
    output logic              tx_transfer_active,
    output logic              rx_data_ready,
    output logic              rx_error,
    output logic              tx_error
);
    state_t            state_q;
    tx_pkt_t           tx_packet_q;
    logic [EP_W-1:0]   active_ep_q;
    logic [NUM_EP-1:0] toggle_q;
    logic              nak_pend_q, send_data_q, send_tx_q, seen_busy_q, restart_q;
    logic              d_mode_q, clear_q, rx_ta_q, tx_ta_q, rx_dr_q, rx_err_q, tx_err_q;
    logic              tmr_exp, is_data, data_bit;

    assign is_data  = rx_packet == PID_DATA0 || rx_packet == PID_DATA1;
    assign data_bit = rx_packet[3];

    protocol_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .restart_i (restart_q),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            tx_packet_q <= TX_NONE;
            active_ep_q <= '0;
            toggle_q    <= '0;
            nak_pend_q  <= 1'b0;
            send_data_q <= 1'b0;
            send_tx_q   <= 1'b0;
            seen_busy_q <= 1'b0;
            restart_q   <= 1'b0;
            d_mode_q    <= 1'b0;
            clear_q     <= 1'b0;
            rx_ta_q     <= 1'b0;
            tx_ta_q     <= 1'b0;
            rx_dr_q     <= 1'b0;
            rx_err_q    <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            restart_q <= 1'b0;
            clear_q   <= 1'b0;
            rx_dr_q   <= 1'b0;
            rx_err_q  <= 1'b0;
            tx_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_packet_valid && rx_packet == PID_OUT) begin
                        active_ep_q <= rx_endpoint;
                        nak_pend_q  <= buffer_reserved || buffer_occupancy != '0;
                        rx_ta_q     <= 1'b1;
                        restart_q   <= 1'b1;
                        state_q     <= ST_RX_DATA;
                    end else if (rx_packet_valid && rx_packet == PID_IN) begin
                        active_ep_q <= rx_endpoint;
                        restart_q   <= 1'b1;
                        seen_busy_q <= 1'b0;
                        send_tx_q   <= 1'b1;
                        d_mode_q    <= 1'b1;
                        state_q     <= ST_SEND;
                        if (ep_stall[rx_endpoint]) begin
                            tx_packet_q <= TX_STALL;
                            send_data_q <= 1'b0;
                        end else if (buffer_reserved || buffer_occupancy < tx_packet_data_size) begin
                            tx_packet_q <= TX_NAK;
                            tx_err_q    <= 1'b1;
                            send_data_q <= 1'b0;
                        end else begin
                            tx_packet_q <= toggle_q[rx_endpoint] ? TX_DATA1 : TX_DATA0;
                            send_data_q <= 1'b1;
                            tx_ta_q     <= 1'b1;
                        end
                    end
                end
                ST_RX_DATA: begin
                    if (rx_packet_valid) begin
                        rx_ta_q     <= 1'b0;
                        restart_q   <= 1'b1;
                        seen_busy_q <= 1'b0;
                        send_tx_q   <= 1'b0;
                        send_data_q <= 1'b0;
                        d_mode_q    <= 1'b1;
                        state_q     <= ST_SEND;
                        if (!is_data) begin
                            rx_err_q    <= 1'b1;
                            clear_q     <= 1'b1;
                            tx_packet_q <= TX_NAK;
                        end else if (ep_stall[active_ep_q]) begin
                            clear_q     <= 1'b1;
                            tx_packet_q <= TX_STALL;
                        end else if (nak_pend_q) begin
                            clear_q     <= 1'b1;
                            tx_packet_q <= TX_NAK;
                        end else if (data_bit == toggle_q[active_ep_q]) begin
                            rx_dr_q               <= 1'b1;
                            toggle_q[active_ep_q] <= ~toggle_q[active_ep_q];
                            tx_packet_q           <= TX_ACK;
                        end else begin
                            // duplicate of an already-acked packet: drop it, re-ack
                            clear_q     <= 1'b1;
                            tx_packet_q <= TX_ACK;
                        end
                    end else if (tmr_exp) begin
                        rx_err_q  <= 1'b1;
                        clear_q   <= 1'b1;
                        rx_ta_q   <= 1'b0;
                        restart_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (!seen_busy_q) begin
                        if (tx_busy) begin
                            seen_busy_q <= 1'b1;
                            tx_packet_q <= TX_NONE;
                        end else if (tmr_exp) begin
                            tx_err_q    <= send_tx_q;
                            rx_err_q    <= !send_tx_q;
                            tx_packet_q <= TX_NONE;
                            d_mode_q    <= 1'b0;
                            tx_ta_q     <= 1'b0;
                            restart_q   <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else if (!tx_busy) begin
                        d_mode_q  <= 1'b0;
                        tx_ta_q   <= send_data_q;
                        restart_q <= 1'b1;
                        state_q   <= send_data_q ? ST_TX_HS : ST_IDLE;
                    end
                end
                default: begin
                    if (rx_packet_valid || tmr_exp) begin
                        if (rx_packet_valid && rx_packet == PID_ACK) toggle_q[active_ep_q] <= ~toggle_q[active_ep_q];
                        else tx_err_q <= 1'b1;
                        tx_ta_q   <= 1'b0;
                        restart_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign d_mode             = d_mode_q;
    assign tx_packet          = tx_packet_q;
    assign active_ep          = active_ep_q;
    assign clear              = clear_q;
    assign rx_transfer_active = rx_ta_q;
    assign tx_transfer_active = tx_ta_q;
    assign rx_data_ready      = rx_dr_q;
    assign rx_error           = rx_err_q;
    assign tx_error           = tx_err_q;
endmodule

// File: tb/tb_protocol_ctrl.sv
// tb_protocol_ctrl: directed transactions against protocol_ctrl, checked with
// hand-computed handshakes, strobes and toggle history
module tb_protocol_ctrl;
    localparam int EP_W  = 2;
    localparam int OCC_W = 7;
    localparam int TMO   = 128;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             rx_packet_valid = 1'b0;
    logic [3:0]       rx_packet = 4'b0;
    logic [EP_W-1:0]  rx_endpoint = '0;
    logic             buffer_reserved = 1'b0;
    logic [OCC_W-1:0] buffer_occupancy = '0;
    logic [OCC_W-1:0] tx_packet_data_size = '0;
    logic             tx_busy = 1'b0;
    logic [3:0]       ep_stall = 4'b0;
    logic             d_mode, clear, rx_transfer_active, tx_transfer_active;
    logic             rx_data_ready, rx_error, tx_error;
    logic [2:0]       tx_packet;
    logic [EP_W-1:0]  active_ep;
    int               checks = 0;
    int               failures = 0;
    int               k;

    protocol_ctrl dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .rx_packet_valid     (rx_packet_valid),
        .rx_packet           (rx_packet),
        .rx_endpoint         (rx_endpoint),
        .buffer_reserved     (buffer_reserved),
        .buffer_occupancy    (buffer_occupancy),
        .tx_packet_data_size (tx_packet_data_size),
        .tx_busy             (tx_busy),
        .ep_stall            (ep_stall),
        .d_mode              (d_mode),
        .tx_packet           (tx_packet),
        .active_ep           (active_ep),
        .clear               (clear),
        .rx_transfer_active  (rx_transfer_active),
        .tx_transfer_active  (tx_transfer_active),
        .rx_data_ready       (rx_data_ready),
        .rx_error            (rx_error),
        .tx_error            (tx_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [3:0] pid, input logic [EP_W-1:0] ep);
        rx_packet_valid = 1'b1;
        rx_packet       = pid;
        rx_endpoint     = ep;
        tick();
        rx_packet_valid = 1'b0;
    endtask

    task automatic complete_send();
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_d_mode", d_mode, 0);
        check("rst_tx_packet", tx_packet, 0);
        check("rst_active_ep", active_ep, 0);
        check("rst_clear", clear, 0);
        check("rst_rx_ta", rx_transfer_active, 0);
        check("rst_tx_ta", tx_transfer_active, 0);
        check("rst_rx_dr", rx_data_ready, 0);
        check("rst_rx_err", rx_error, 0);
        check("rst_tx_err", tx_error, 0);
        n_rst = 1'b1;
        tick();
        // IN ep0, enough data queued -> DATA0; host answers with a non-ACK PID
        buffer_occupancy = 7'd8;
        tx_packet_data_size = 7'd8;
        send_pkt(4'b1001, 2'd0);
        check("in0_pkt", tx_packet, 3'b100);
        check("in0_dmode", d_mode, 1);
        check("in0_tx_ta", tx_transfer_active, 1);
        check("in0_tx_err", tx_error, 0);
        tx_busy = 1'b1;
        tick();
        check("in0_pkt_none", tx_packet, 0);
        check("in0_dmode_busy", d_mode, 1);
        tx_busy = 1'b0;
        tick();
        check("in0_hs_dmode", d_mode, 0);
        check("in0_hs_tx_ta", tx_transfer_active, 1);
        send_pkt(4'b0011, 2'd0);
        check("in0_badhs_err", tx_error, 1);
        check("in0_badhs_tx_ta", tx_transfer_active, 0);
        tick();
        check("in0_err_strobe", tx_error, 0);
        // OUT ep2 data, duplicate, then next data
        buffer_occupancy = '0;
        send_pkt(4'b0001, 2'd2);
        check("out2_rx_ta", rx_transfer_active, 1);
        check("out2_ep", active_ep, 2);
        send_pkt(4'b0011, 2'd0);
        check("out2_d0_rdy", rx_data_ready, 1);
        check("out2_d0_pkt", tx_packet, 3'b001);
        check("out2_d0_dmode", d_mode, 1);
        check("out2_d0_clear", clear, 0);
        check("out2_d0_rx_ta", rx_transfer_active, 0);
        send_pkt(4'b0001, 2'd2);
        complete_send();
        check("send_ignores_tok", rx_transfer_active, 0);
        send_pkt(4'b0001, 2'd2);
        send_pkt(4'b0011, 2'd0);
        check("out2_dup_rdy", rx_data_ready, 0);
        check("out2_dup_clear", clear, 1);
        check("out2_dup_pkt", tx_packet, 3'b001);
        complete_send();
        send_pkt(4'b0001, 2'd2);
        send_pkt(4'b1011, 2'd0);
        check("out2_d1_rdy", rx_data_ready, 1);
        check("out2_d1_pkt", tx_packet, 3'b001);
        complete_send();
        // OUT ep1 with CPU owning buffer -> NAK, toggle untouched
        buffer_reserved = 1'b1;
        send_pkt(4'b0001, 2'd1);
        send_pkt(4'b0011, 2'd0);
        check("out1_nak_pkt", tx_packet, 3'b010);
        check("out1_nak_clear", clear, 1);
        check("out1_nak_rdy", rx_data_ready, 0);
        complete_send();
        buffer_reserved = 1'b0;
        send_pkt(4'b0001, 2'd1);
        send_pkt(4'b1011, 2'd0);
        check("out1_d1_dup_clear", clear, 1);
        check("out1_d1_dup_rdy", rx_data_ready, 0);
        complete_send();
        send_pkt(4'b0001, 2'd1);
        send_pkt(4'b0011, 2'd0);
        check("out1_d0_rdy", rx_data_ready, 1);
        complete_send();
        send_pkt(4'b0001, 2'd1);
        send_pkt(4'b1100, 2'd0);
        check("out1_bad_rx_err", rx_error, 1);
        check("out1_bad_clear", clear, 1);
        check("out1_bad_pkt", tx_packet, 3'b010);
        complete_send();
        // IN ep3: short buffer -> NAK, then stalled -> STALL
        buffer_occupancy = 7'd4;
        tx_packet_data_size = 7'd10;
        send_pkt(4'b1001, 2'd3);
        check("in3_short_err", tx_error, 1);
        check("in3_short_pkt", tx_packet, 3'b010);
        check("in3_short_tx_ta", tx_transfer_active, 0);
        check("in3_ep", active_ep, 3);
        complete_send();
        ep_stall = 4'b1000;
        send_pkt(4'b1001, 2'd3);
        check("in3_stall_pkt", tx_packet, 3'b011);
        check("in3_stall_err", tx_error, 0);
        complete_send();
        ep_stall = 4'b0000;
        // IN ep0: host silent -> timeout, resend DATA0, ACK, then DATA1
        buffer_occupancy = 7'd8;
        tx_packet_data_size = 7'd8;
        send_pkt(4'b1001, 2'd0);
        check("in0b_pkt", tx_packet, 3'b100);
        complete_send();
        k = 0;
        while (!tx_error && k < 300) begin
            tick();
            k++;
        end
        check("hs_timeout_cycles", k[7:0], 8'(TMO + 1));
        check("hs_timeout_tx_ta", tx_transfer_active, 0);
        send_pkt(4'b1001, 2'd0);
        check("in0_resend_pkt", tx_packet, 3'b100);
        complete_send();
        send_pkt(4'b0010, 2'd0);
        check("in0_ack_err", tx_error, 0);
        check("in0_ack_tx_ta", tx_transfer_active, 0);
        send_pkt(4'b1001, 2'd0);
        check("in0_d1_pkt", tx_packet, 3'b101);
        complete_send();
        send_pkt(4'b0010, 2'd0);
        // OUT ep0 with host never sending data -> rx timeout
        buffer_occupancy = '0;
        send_pkt(4'b0001, 2'd0);
        k = 0;
        while (!rx_error && k < 300) begin
            tick();
            k++;
        end
        check("rx_timeout_cycles", k[7:0], 8'(TMO + 1));
        check("rx_timeout_clear", clear, 1);
        check("rx_timeout_pkt", tx_packet, 0);
        check("rx_timeout_dmode", d_mode, 0);
        check("rx_timeout_rx_ta", rx_transfer_active, 0);
        // zero-length IN on ep3, reset mid-send
        tx_packet_data_size = '0;
        send_pkt(4'b1001, 2'd3);
        check("zlp_pkt", tx_packet, 3'b100);
        check("zlp_err", tx_error, 0);
        n_rst = 1'b0;
        tick();
        check("midrst_dmode", d_mode, 0);
        check("midrst_pkt", tx_packet, 0);
        check("midrst_tx_ta", tx_transfer_active, 0);
        check("midrst_tx_err", tx_error, 0);
        check("midrst_ep", active_ep, 0);
        n_rst = 1'b1;
        tick();
        // toggle[1] was 1 before reset; DATA0 must now be accepted as new
        send_pkt(4'b0001, 2'd1);
        send_pkt(4'b0011, 2'd0);
        check("postrst_rdy", rx_data_ready, 1);
        check("postrst_pkt", tx_packet, 3'b001);
        complete_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
